// File: rtl/mac_array_ctrl_pkg.sv
// Shared encodings for the MAC array sequencer: FSM states, per-row
// instruction codes and array mode values.
package mac_array_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Per-row instruction: bit0 = load, bit1 = execute.
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_array_ctrl_inst_skew.sv
// Row skew for the array instruction bus: row r sees the row-0 instruction
// delayed by r cycles, so each row starts one beat after the row above it.
module mac_array_ctrl_inst_skew
  import mac_array_ctrl_pkg::*;
#(
  parameter int row = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inst0_i,
  output logic [2*row-1:0] inst_w_o
);

  if (row > 1) begin : g_skew
    logic [2*(row-1)-1:0] shift_q;
    logic [2*row-1:0]     chain;

    // Row 0 passes straight through; rows 1..row-1 come from the delay line.
    assign chain    = {shift_q, inst0_i};
    assign inst_w_o = chain;

    // NOTE: the delay line is reset explicitly so an aborted pass cannot leave
    // stale load/execute codes travelling down the rows after reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        shift_q <= {(row-1){INST_IDLE}};
      end else begin
        shift_q <= chain[2*(row-1)-1:0];
      end
    end
  end else begin : g_single
    assign inst_w_o = inst0_i;
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile-pass sequencer for the MAC array: CLR -> LOAD -> EXEC -> (OS) FLUSH ->
// DRAIN -> DONE, with L0 stalls on load/execute beats and per-row skew.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              os_mode,
  input  logic [cnt_bw-1:0] k_len,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [2*row-1:0]  inst_w,
  output logic              mode,
  output logic              acc_clr,
  output logic              busy,
  output logic              done
);

  localparam logic [cnt_bw-1:0] LOAD_LAST  = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] FLUSH_LAST = cnt_bw'(row - 1);
  localparam logic [cnt_bw-1:0] DRAIN_LAST = cnt_bw'(row + col - 1);

  state_e            state_q, state_d;
  logic [cnt_bw-1:0] cnt_q, cnt_d;
  logic [cnt_bw-1:0] k_q, k_d;
  logic              os_q, os_d;
  logic              mode_q, acc_clr_q, busy_q, done_q;
  logic              issue;
  logic [1:0]        inst0;

  // Next-state, beat counting and the row-0 instruction. Stalls only affect
  // LOAD/EXEC; the counter advances on issued beats, not on cycles.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    os_d    = os_q;
    issue   = 1'b0;
    inst0   = INST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          os_d    = os_mode;
          k_d     = k_len;
          cnt_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        cnt_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!l0_empty) begin
          issue = 1'b1;
          inst0 = INST_LOAD;
          if (cnt_q == LOAD_LAST) begin
            cnt_d = '0;
            if (k_q == '0) state_d = os_q ? ST_FLUSH : ST_DRAIN;
            else           state_d = ST_EXEC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (!l0_empty) begin
          issue = 1'b1;
          inst0 = INST_EXEC;
          if (cnt_q == k_q - 1'b1) begin
            cnt_d   = '0;
            state_d = os_q ? ST_FLUSH : ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // Keeps execute issued with accumulation off so results shift out.
        inst0 = INST_EXEC;
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State plus registered status outputs, decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      os_q      <= MODE_WS;
      mode_q    <= MODE_WS;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      os_q      <= os_d;
      mode_q    <= (os_d == MODE_OS &&
                    (state_d == ST_CLR || state_d == ST_LOAD || state_d == ST_EXEC))
                   ? MODE_OS : MODE_WS;
      acc_clr_q <= (state_d == ST_CLR);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign l0_rd   = issue;
  assign mode    = mode_q;
  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  mac_array_ctrl_inst_skew #(
    .row (row)
  ) u_inst_skew (
    .clk      (clk),
    .reset    (reset),
    .inst0_i  (inst0),
    .inst_w_o (inst_w)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl with row=col=4: per-cycle traces of every
// output are recorded per pass and compared with hand-derived cycle ranges.
module tb_mac_array_ctrl;

  localparam int ROW  = 4;
  localparam int COL  = 4;
  localparam int NCYC = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       os_mode;
  logic [7:0] k_len;
  logic       l0_empty;
  logic       l0_rd;
  logic [7:0] inst_w;
  logic       mode;
  logic       acc_clr;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  logic [63:0] tr_l0rd, tr_acc, tr_mode, tr_busy, tr_done;
  logic [63:0] tr_r0ld, tr_r0ex, tr_r3ld, tr_r3ex, tr_nz;

  mac_array_ctrl #(
    .row    (ROW),
    .col    (COL),
    .cnt_bw (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .os_mode  (os_mode),
    .k_len    (k_len),
    .l0_empty (l0_empty),
    .l0_rd    (l0_rd),
    .inst_w   (inst_w),
    .mode     (mode),
    .acc_clr  (acc_clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = 0; i < 64; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  task automatic sample(input int c);
    tr_l0rd[c] = l0_rd;
    tr_acc[c]  = acc_clr;
    tr_mode[c] = mode;
    tr_busy[c] = busy;
    tr_done[c] = done;
    tr_r0ld[c] = (inst_w[1:0] == 2'b01);
    tr_r0ex[c] = (inst_w[1:0] == 2'b10);
    tr_r3ld[c] = (inst_w[7:6] == 2'b01);
    tr_r3ex[c] = (inst_w[7:6] == 2'b10);
    tr_nz[c]   = (inst_w != 8'h00);
  endtask

  // Cycle 0 carries the start pulse; later cycles apply per-cycle masks.
  // os_mode/k_len are scrambled after cycle 0 to show they were latched.
  task automatic run_pass(input logic os, input logic [7:0] kl,
                          input logic [63:0] stall_m, input logic [63:0] start_m,
                          input logic [63:0] rst_m);
    {tr_l0rd, tr_acc, tr_mode, tr_busy, tr_done} = '0;
    {tr_r0ld, tr_r0ex, tr_r3ld, tr_r3ex, tr_nz}  = '0;
    @(negedge clk);
    start = 1'b1; os_mode = os; k_len = kl; l0_empty = 1'b0; reset = 1'b0;
    sample(0);
    for (int c = 1; c < NCYC; c++) begin
      @(posedge clk); #1;
      start    = start_m[c];
      os_mode  = ~os;
      k_len    = 8'd2;
      l0_empty = stall_m[c];
      reset    = rst_m[c];
      @(negedge clk);
      sample(c);
    end
    start = 1'b0; l0_empty = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; os_mode = 1'b1; k_len = 8'd5; l0_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({l0_rd, inst_w, mode, acc_clr, busy, done} !== 13'h0)
      $display("FAIL reset_outputs got=%h exp=0", {l0_rd, inst_w, mode, acc_clr, busy, done}); else passed++;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if ({l0_rd, inst_w, mode, acc_clr, busy, done} !== 13'h0)
      $display("FAIL start_with_reset got=%h exp=0", {l0_rd, inst_w, mode, acc_clr, busy, done}); else passed++;
  endtask

  task automatic test_ws_pass;
    run_pass(1'b0, 8'd6, '0, '0, '0);
    total++; if (tr_acc  !== rng(1, 1))   $display("FAIL ws_acc_clr got=%h exp=%h", tr_acc, rng(1, 1)); else passed++;
    total++; if (tr_r0ld !== rng(2, 5))   $display("FAIL ws_row0_load got=%h exp=%h", tr_r0ld, rng(2, 5)); else passed++;
    total++; if (tr_r0ex !== rng(6, 11))  $display("FAIL ws_row0_exec got=%h exp=%h", tr_r0ex, rng(6, 11)); else passed++;
    total++; if (tr_l0rd !== rng(2, 11))  $display("FAIL ws_l0_rd got=%h exp=%h", tr_l0rd, rng(2, 11)); else passed++;
    total++; if (tr_mode !== 64'h0)       $display("FAIL ws_mode got=%h exp=0", tr_mode); else passed++;
    total++; if (tr_busy !== rng(1, 20))  $display("FAIL ws_busy got=%h exp=%h", tr_busy, rng(1, 20)); else passed++;
    total++; if (tr_done !== rng(20, 20)) $display("FAIL ws_done got=%h exp=%h", tr_done, rng(20, 20)); else passed++;
  endtask

  task automatic test_os_pass;
    run_pass(1'b1, 8'd6, '0, '0, '0);
    total++; if (tr_mode !== rng(1, 11))  $display("FAIL os_mode got=%h exp=%h", tr_mode, rng(1, 11)); else passed++;
    total++; if (tr_r0ex !== rng(6, 15))  $display("FAIL os_row0_exec_flush got=%h exp=%h", tr_r0ex, rng(6, 15)); else passed++;
    total++; if (tr_l0rd !== rng(2, 11))  $display("FAIL os_l0_rd got=%h exp=%h", tr_l0rd, rng(2, 11)); else passed++;
    total++; if (tr_busy !== rng(1, 24))  $display("FAIL os_busy got=%h exp=%h", tr_busy, rng(1, 24)); else passed++;
    total++; if (tr_done !== rng(24, 24)) $display("FAIL os_done got=%h exp=%h", tr_done, rng(24, 24)); else passed++;
  endtask

  task automatic test_skew;
    run_pass(1'b1, 8'd6, '0, '0, '0);
    total++; if (tr_r3ld !== rng(5, 8))  $display("FAIL skew_row3_load got=%h exp=%h", tr_r3ld, rng(5, 8)); else passed++;
    total++; if (tr_r3ex !== rng(9, 18)) $display("FAIL skew_row3_exec got=%h exp=%h", tr_r3ex, rng(9, 18)); else passed++;
    total++; if (tr_nz   !== rng(2, 18)) $display("FAIL skew_nonzero_span got=%h exp=%h", tr_nz, rng(2, 18)); else passed++;
  endtask

  task automatic test_stall;
    run_pass(1'b0, 8'd6, rng(7, 9), '0, '0);
    total++; if (tr_l0rd !== (rng(2, 6) | rng(10, 14)))
      $display("FAIL stall_l0_rd got=%h exp=%h", tr_l0rd, rng(2, 6) | rng(10, 14)); else passed++;
    total++; if (tr_r0ex !== (rng(6, 6) | rng(10, 14)))
      $display("FAIL stall_row0_exec got=%h exp=%h", tr_r0ex, rng(6, 6) | rng(10, 14)); else passed++;
    total++; if ($countones(tr_l0rd) !== 10)
      $display("FAIL stall_l0_rd_count got=%0d exp=10", $countones(tr_l0rd)); else passed++;
    total++; if (tr_done !== rng(23, 23)) $display("FAIL stall_done got=%h exp=%h", tr_done, rng(23, 23)); else passed++;
    total++; if (tr_busy !== rng(1, 23))  $display("FAIL stall_busy got=%h exp=%h", tr_busy, rng(1, 23)); else passed++;
  endtask

  task automatic test_k_zero;
    run_pass(1'b0, 8'd0, '0, '0, '0);
    total++; if (tr_r0ex !== 64'h0)       $display("FAIL k0_row0_exec got=%h exp=0", tr_r0ex); else passed++;
    total++; if (tr_l0rd !== rng(2, 5))   $display("FAIL k0_l0_rd got=%h exp=%h", tr_l0rd, rng(2, 5)); else passed++;
    total++; if (tr_done !== rng(14, 14)) $display("FAIL k0_done got=%h exp=%h", tr_done, rng(14, 14)); else passed++;
    total++; if (tr_nz   !== rng(2, 8))   $display("FAIL k0_nonzero_span got=%h exp=%h", tr_nz, rng(2, 8)); else passed++;
  endtask

  task automatic test_start_while_busy;
    run_pass(1'b0, 8'd6, '0, rng(5, 5) | rng(20, 20), '0);
    total++; if (tr_busy !== rng(1, 20))  $display("FAIL busy_start_busy got=%h exp=%h", tr_busy, rng(1, 20)); else passed++;
    total++; if (tr_done !== rng(20, 20)) $display("FAIL busy_start_done got=%h exp=%h", tr_done, rng(20, 20)); else passed++;
    total++; if (tr_acc  !== rng(1, 1))   $display("FAIL busy_start_acc_clr got=%h exp=%h", tr_acc, rng(1, 1)); else passed++;
  endtask

  task automatic test_reset_mid_pass;
    run_pass(1'b1, 8'd6, '0, '0, rng(8, 8));
    total++; if (tr_busy !== rng(1, 8)) $display("FAIL abort_busy got=%h exp=%h", tr_busy, rng(1, 8)); else passed++;
    total++; if (tr_done !== 64'h0)     $display("FAIL abort_done got=%h exp=0", tr_done); else passed++;
    total++; if (tr_mode !== rng(1, 8)) $display("FAIL abort_mode got=%h exp=%h", tr_mode, rng(1, 8)); else passed++;
    total++; if (tr_l0rd !== rng(2, 8)) $display("FAIL abort_l0_rd got=%h exp=%h", tr_l0rd, rng(2, 8)); else passed++;
    total++; if (tr_nz   !== rng(2, 8)) $display("FAIL abort_inst_w got=%h exp=%h", tr_nz, rng(2, 8)); else passed++;
    run_pass(1'b0, 8'd6, '0, '0, '0);
    total++; if (tr_done !== rng(20, 20)) $display("FAIL rerun_done got=%h exp=%h", tr_done, rng(20, 20)); else passed++;
    total++; if (tr_l0rd !== rng(2, 11))  $display("FAIL rerun_l0_rd got=%h exp=%h", tr_l0rd, rng(2, 11)); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; os_mode = 1'b0; k_len = '0; l0_empty = 1'b0;
    test_reset();
    test_ws_pass();
    test_os_pass();
    test_skew();
    test_stall();
    test_k_zero();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
